wb_lms_seq: RTL

//  Wishbone master sequencer for the wb_lms adaptive filter. Takes input samples

---
 rtl/wb_lms_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_lms_seq.sv
// wb_lms_seq: Wishbone master sequencer for the wb_lms adaptive filter.
// Each accepted sample is written to the LMS, allowed to settle, then y_out and
// err are read back and presented as one result beat.
// Optional feature macro: WB_LMS_SEQ_DESIRED_EN (adds a desired-sample write
// to ADR_D ahead of the x write).
module wb_lms_seq #(
  parameter logic [3:0] ADR_X       = 4'h0,
  parameter logic [3:0] ADR_D       = 4'h1,
  parameter logic [3:0] ADR_Y       = 4'h2,
  parameter logic [3:0] ADR_E       = 4'h3,
  parameter int         SETTLE_CYC  = 4,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        enable_i,
  input  logic        clr_err_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [15:0] s_x_i,
  input  logic [15:0] s_d_i,
  output logic        r_valid_o,
  input  logic        r_ready_i,
  output logic [15:0] r_y_o,
  output logic [15:0] r_err_o,
  output logic [3:0]  wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  input  logic [15:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        to_err_o,
  output logic [15:0] smp_cnt_o
);

  localparam int            TW      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam int            SW      = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SET_LD  = SW'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_D, S_WR_X, S_SETTLE, S_RD_Y, S_RD_E, S_OUT
  } state_t;

  state_t        r_state, w_nxt;
  logic          r_stb, r_we, r_done, r_valid, r_to_err;
  logic [3:0]    r_adr;
  logic [15:0]   r_dat, r_y, r_err, r_smp_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [SW-1:0] r_set_cnt;
`ifdef WB_LMS_SEQ_DESIRED_EN
  logic [15:0]   r_x;
`endif

  logic          w_ack, w_expire, w_accept, w_launch, w_l_we;
  logic [3:0]    w_l_adr;
  logic [15:0]   w_l_dat;
  logic          w_unused;

  // Ack only counts while strobing; a late ack in a non-bus cycle is dropped.
  // Ack wins over timeout expiry in the same cycle.
  assign w_ack     = r_stb & wbm_ack_i;
  assign w_expire  = r_stb & ~wbm_ack_i & (r_to_cnt == TO_LAST);
  assign w_accept  = s_ready_o & s_valid_i;
  assign w_unused  = &{1'b0, s_d_i, ADR_D};

  assign s_ready_o = wb_rst_n_i & enable_i & (r_state == S_IDLE);
  assign r_valid_o = r_valid;
  assign r_y_o     = r_y;
  assign r_err_o   = r_err;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_we_o  = r_we;
  assign wbm_stb_o = r_stb;
  assign wbm_cyc_o = r_stb;
  assign to_err_o  = r_to_err;
  assign smp_cnt_o = r_smp_cnt;

  // Next state plus the bus request to launch when a bus state is entered.
  // WR_D and RD_Y hold one extra cycle (r_done) after ack so the next strobe
  // is separated by an idle bus cycle; WR_X uses SETTLE and RD_E uses OUT.
  always_comb begin
    w_nxt    = r_state;
    w_launch = 1'b0;
    w_l_adr  = '0;
    w_l_we   = 1'b0;
    w_l_dat  = '0;
    case (r_state)
      S_IDLE: if (w_accept) begin
`ifdef WB_LMS_SEQ_DESIRED_EN
        w_nxt = S_WR_D;
`else
        w_nxt = S_WR_X;
`endif
      end
`ifdef WB_LMS_SEQ_DESIRED_EN
      S_WR_D:   if (w_expire) w_nxt = S_IDLE; else if (r_done) w_nxt = S_WR_X;
`endif
      S_WR_X:   if (w_expire) w_nxt = S_IDLE; else if (w_ack) w_nxt = S_SETTLE;
      S_SETTLE: if (r_set_cnt == '0) w_nxt = S_RD_Y;
      S_RD_Y:   if (w_expire) w_nxt = S_IDLE; else if (r_done) w_nxt = S_RD_E;
      S_RD_E:   if (w_expire) w_nxt = S_IDLE; else if (w_ack) w_nxt = S_OUT;
      S_OUT:    if (r_ready_i) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
    if (w_nxt != r_state) begin
      case (w_nxt)
`ifdef WB_LMS_SEQ_DESIRED_EN
        S_WR_D: begin w_launch = 1'b1; w_l_adr = ADR_D; w_l_we = 1'b1; w_l_dat = s_d_i; end
        S_WR_X: begin w_launch = 1'b1; w_l_adr = ADR_X; w_l_we = 1'b1; w_l_dat = r_x;   end
`else
        S_WR_X: begin w_launch = 1'b1; w_l_adr = ADR_X; w_l_we = 1'b1; w_l_dat = s_x_i; end
`endif
        S_RD_Y: begin w_launch = 1'b1; w_l_adr = ADR_Y; end
        S_RD_E: begin w_launch = 1'b1; w_l_adr = ADR_E; end
        default: ;
      endcase
    end
  end

  // State register, bus outputs, counters and result capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= S_IDLE;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_to_err  <= 1'b0;
      r_y       <= '0;
      r_err     <= '0;
      r_smp_cnt <= '0;
      r_to_cnt  <= '0;
      r_set_cnt <= '0;
`ifdef WB_LMS_SEQ_DESIRED_EN
      r_x       <= '0;
`endif
    end else begin
      r_state <= w_nxt;
      r_done  <= w_ack;
      r_valid <= (w_nxt == S_OUT);
`ifdef WB_LMS_SEQ_DESIRED_EN
      if (w_accept) r_x <= s_x_i;
`endif
      if (w_launch) begin
        r_stb <= 1'b1;
        r_adr <= w_l_adr;
        r_we  <= w_l_we;
        r_dat <= w_l_dat;
      end else if (w_ack || w_expire) begin
        r_stb <= 1'b0;
        r_adr <= '0;
        r_we  <= 1'b0;
        r_dat <= '0;
      end
      r_to_cnt <= (r_stb && !wbm_ack_i && !w_expire) ? r_to_cnt + 1'b1 : '0;
      if (r_state == S_WR_X && w_ack)
        r_set_cnt <= SET_LD;
      else if (r_state == S_SETTLE && r_set_cnt != '0)
        r_set_cnt <= r_set_cnt - 1'b1;
      if (r_state == S_RD_Y && w_ack) r_y   <= wbm_dat_i;
      if (r_state == S_RD_E && w_ack) r_err <= wbm_dat_i;
      if (r_state == S_OUT && r_ready_i) r_smp_cnt <= r_smp_cnt + 1'b1;
      if (w_expire)       r_to_err <= 1'b1;
      else if (clr_err_i) r_to_err <= 1'b0;
    end
  end

endmodule
